// File: rtl/cm_config_master_if.sv
`default_nettype none
// ============================================================================
// Module      : cm_config_master_if
// Description : Signal bundle for the CM configuration master. It carries the
//               command-side handshake (cmd_*) and the configuration bus
//               (c_*). The bus valid is active low. c_ready idles high and is
//               pulsed low by the addressed responder.
// Ports       : none; signals only.
//   master modport : seen from cm_config_master
//                    in : cmd_addr, cmd_data, cmd_valid, c_ready
//                    out: cmd_ready, c_addr, c_data, c_valid
//   slave  modport : seen from the command source and bus responder
//                    (the same signals with directions swapped)
// Revision    : 1.0 - initial release
// ============================================================================
interface cm_config_master_if #(
    parameter int c_addr_WIDTH = 4,
    parameter int c_data_WIDTH = 16
) ();
    // Command side
    logic [c_addr_WIDTH-1:0] cmd_addr;
    logic [c_data_WIDTH-1:0] cmd_data;
    logic                    cmd_valid;
    logic                    cmd_ready;

    // Configuration bus side
    logic [c_addr_WIDTH-1:0] c_addr;
    logic [c_data_WIDTH-1:0] c_data;
    logic                    c_valid;   // active low
    logic                    c_ready;   // pulsed low by responder

    modport master (
        input  cmd_addr, cmd_data, cmd_valid, c_ready,
        output cmd_ready, c_addr, c_data, c_valid
    );

    modport slave (
        output cmd_addr, cmd_data, cmd_valid, c_ready,
        input  cmd_ready, c_addr, c_data, c_valid
    );
endinterface
`default_nettype wire

// File: rtl/cm_config_master.sv
`default_nettype none
// ============================================================================
// Module      : cm_config_master
// Description : Initiator for the CM configuration bus. Write commands are
//               queued in a small FIFO and issued one at a time with an
//               active-low valid / ready-pulse handshake. Any transfer that is
//               not acknowledged, and any release phase that stalls, is
//               abandoned after a bounded timeout and flagged.
// Ports       : clk         - clock, rising edge
//               rst         - synchronous active-high reset
//               bus         - cm_config_master_if.master (cmd_* and c_*)
//               timeout_clr - clears the sticky timeout flag
//               busy        - FSM not idle or FIFO not empty
//               timeout_err - sticky timeout flag
//               tx_count    - acknowledged transfers, wraps at 256
// Revision    : 1.0 - initial release
// ============================================================================
module cm_config_master #(
    parameter int c_addr_WIDTH   = 4,
    parameter int c_data_WIDTH   = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_WIDTH  = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    cm_config_master_if.master     bus,
    input  wire logic              timeout_clr,
    output logic                   busy,
    output logic                   timeout_err,
    output logic [7:0]             tx_count
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = c_addr_WIDTH + c_data_WIDTH;

    localparam logic [CNT_W-1:0]         FIFO_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [TIMEOUT_WIDTH-1:0] TIMER_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DRIVE     = 2'd1,
        ST_WAIT_IDLE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic w_cmd_ready;
    logic w_push;
    logic w_pop;

    // Readiness depends only on the registered count, so a pop in the same
    // cycle never lets a push slip into a full FIFO.
    assign w_cmd_ready   = (r_count != FIFO_FULL);
    assign w_push        = bus.cmd_valid & w_cmd_ready;
    assign bus.cmd_ready = w_cmd_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.cmd_addr, bus.cmd_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bus FSM
    // ------------------------------------------------------------------
    state_t                   r_state;
    state_t                   w_state_next;
    logic                     r_c_valid;
    logic                     w_c_valid_next;
    logic [c_addr_WIDTH-1:0]  r_c_addr;
    logic [c_data_WIDTH-1:0]  r_c_data;
    logic [TIMEOUT_WIDTH-1:0] r_timer;
    logic [TIMEOUT_WIDTH-1:0] w_timer_next;
    logic                     w_load;
    logic                     w_tx_inc;
    logic                     w_to_set;
    logic                     r_timeout_err;
    logic [7:0]               r_tx_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_c_valid     <= 1'b1;
            r_c_addr      <= '0;
            r_c_data      <= '0;
            r_timer       <= '0;
            r_timeout_err <= 1'b0;
            r_tx_count    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_c_valid <= w_c_valid_next;
            r_timer   <= w_timer_next;
            if (w_load) begin
                {r_c_addr, r_c_data} <= r_mem[r_rd_ptr];
            end
            if (w_tx_inc) begin
                r_tx_count <= r_tx_count + 8'd1;
            end
            // A new timeout wins over a simultaneous clear.
            if (w_to_set) begin
                r_timeout_err <= 1'b1;
            end else if (timeout_clr) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_c_valid_next = r_c_valid;
        w_timer_next   = r_timer;
        w_pop          = 1'b0;
        w_load         = 1'b0;
        w_tx_inc       = 1'b0;
        w_to_set       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_c_valid_next = 1'b1;
                w_timer_next   = '0;
                if (r_count != '0) begin
                    w_pop          = 1'b1;
                    w_load         = 1'b1;
                    w_c_valid_next = 1'b0;
                    w_state_next   = ST_DRIVE;
                end
            end

            ST_DRIVE: begin
                if (!bus.c_ready) begin
                    w_c_valid_next = 1'b1;
                    w_tx_inc       = 1'b1;
                    w_timer_next   = '0;
                    w_state_next   = ST_WAIT_IDLE;
                end else if (r_timer == TIMER_LAST) begin
                    // Unacknowledged write is dropped, not retried.
                    w_c_valid_next = 1'b1;
                    w_to_set       = 1'b1;
                    w_timer_next   = '0;
                    w_state_next   = ST_WAIT_IDLE;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end

            ST_WAIT_IDLE: begin
                // Hold off the next transfer until the responder's ready
                // pulse has finished, so it is not mistaken for a new ack.
                if (bus.c_ready) begin
                    w_timer_next = '0;
                    w_state_next = ST_IDLE;
                end else if (r_timer == TIMER_LAST) begin
                    w_to_set     = 1'b1;
                    w_timer_next = '0;
                    w_state_next = ST_IDLE;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end

            default: begin
                w_c_valid_next = 1'b1;
                w_timer_next   = '0;
                w_state_next   = ST_IDLE;
            end
        endcase
    end

    assign bus.c_valid = r_c_valid;
    assign bus.c_addr  = r_c_addr;
    assign bus.c_data  = r_c_data;
    assign busy        = (r_state != ST_IDLE) || (r_count != '0);
    assign timeout_err = r_timeout_err;
    assign tx_count    = r_tx_count;

endmodule
`default_nettype wire
